// File: rtl/block_memory_arbiter_pkg.sv
// Shared types and constants for the block RAM port-A arbiter.
// Banks are 2048 words, so the bank index is the address above bit 11.
package block_memory_arbiter_pkg;

  localparam int BANK_WORDS = 2048;
  localparam int BANK_SHIFT = 11;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WE_W       = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_R0   = 2'd1,
    GRANT_R1   = 2'd2
  } grant_e;

  typedef struct packed {
    logic              valid;
    logic              error;
    logic [DATA_W-1:0] data;
  } rsp_t;

  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                             input int unsigned       blocks);
    return (addr >> BANK_SHIFT) >= blocks;
  endfunction

endpackage

// File: rtl/block_memory_arbiter_response.sv
// Registered response demux: remembers who was granted and whether the access
// was a write or an error, then steers the next-cycle RAM read data back.
module block_memory_arbiter_response
  import block_memory_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              xfer,
  input  logic              xfer_id,
  input  logic              xfer_error,
  input  logic              xfer_write,
  input  logic [DATA_W-1:0] mem_read_output,
  output rsp_t              r0_rsp,
  output rsp_t              r1_rsp
);

  logic pend_valid_q, pend_valid_d;
  logic pend_id_q,    pend_id_d;
  logic pend_error_q, pend_error_d;
  logic pend_write_q, pend_write_d;
  logic              live;
  logic [DATA_W-1:0] rsp_data;

  always_comb begin
    pend_valid_d = xfer;
    pend_id_d    = xfer ? xfer_id    : pend_id_q;
    pend_error_d = xfer ? xfer_error : 1'b0;
    pend_write_d = xfer ? xfer_write : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_id_q    <= 1'b0;
      pend_error_q <= 1'b0;
      pend_write_q <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      pend_error_q <= pend_error_d;
      pend_write_q <= pend_write_d;
    end
  end

  // A response still in flight when reset arrives is dropped, not delivered.
  always_comb begin
    live     = pend_valid_q && !reset;
    rsp_data = (live && !pend_error_q && !pend_write_q) ? mem_read_output : '0;
    r0_rsp   = '0;
    r1_rsp   = '0;
    if (live && !pend_id_q) begin
      r0_rsp.valid = 1'b1;
      r0_rsp.error = pend_error_q;
      r0_rsp.data  = rsp_data;
    end
    if (live && pend_id_q) begin
      r1_rsp.valid = 1'b1;
      r1_rsp.error = pend_error_q;
      r1_rsp.data  = rsp_data;
    end
  end

endmodule

// File: rtl/block_memory_arbiter.sv
// Two-requester arbiter for block RAM port A: requester 0 has priority, and a
// starvation counter forces a requester 1 grant after STARVE_LIMIT waits.
module block_memory_arbiter
  import block_memory_arbiter_pkg::*;
#(
  parameter int unsigned RAM_BLOCKS   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [WE_W-1:0]   r0_write_enable,
  input  logic [DATA_W-1:0] r0_write_data,
  output logic              r0_rsp_valid,
  output logic              r0_rsp_error,
  output logic [DATA_W-1:0] r0_rsp_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [WE_W-1:0]   r1_write_enable,
  input  logic [DATA_W-1:0] r1_write_data,
  output logic              r1_rsp_valid,
  output logic              r1_rsp_error,
  output logic [DATA_W-1:0] r1_rsp_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WE_W-1:0]   mem_write_enable,
  output logic [DATA_W-1:0] mem_write_input,
  input  logic [DATA_W-1:0] mem_read_output
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0]  starve_count_q, starve_count_d;
  logic        force1;
  grant_e      grant;
  logic        sel_oor;
  logic [WE_W-1:0] sel_we;
  rsp_t        r0_rsp, r1_rsp;

  // Grant is purely combinational so a request can be accepted the cycle it appears.
  always_comb begin
    force1 = (starve_count_q == STARVE_MAX);
    grant  = GRANT_NONE;
    if (!reset) begin
      if (r1_valid && (force1 || !r0_valid)) grant = GRANT_R1;
      else if (r0_valid)                     grant = GRANT_R0;
    end
    r0_ready = (grant == GRANT_R0);
    r1_ready = (grant == GRANT_R1);
  end

  always_comb begin
    mem_address     = (grant == GRANT_R1) ? r1_address      : r0_address;
    mem_write_input = (grant == GRANT_R1) ? r1_write_data   : r0_write_data;
    sel_we          = (grant == GRANT_R1) ? r1_write_enable : r0_write_enable;
    sel_oor         = addr_out_of_range(mem_address, RAM_BLOCKS);
    mem_write_enable = (grant != GRANT_NONE && !sel_oor) ? sel_we : '0;
  end

  always_comb begin
    starve_count_d = 8'd0;
    if (r1_valid && !r1_ready)
      starve_count_d = force1 ? starve_count_q : starve_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_count_q <= 8'd0;
    else       starve_count_q <= starve_count_d;
  end

  block_memory_arbiter_response u_response (
    .clk             (clk),
    .reset           (reset),
    .xfer            (grant != GRANT_NONE),
    .xfer_id         (grant == GRANT_R1),
    .xfer_error      (sel_oor),
    .xfer_write      (sel_we != '0),
    .mem_read_output (mem_read_output),
    .r0_rsp          (r0_rsp),
    .r1_rsp          (r1_rsp)
  );

  always_comb begin
    r0_rsp_valid = r0_rsp.valid;
    r0_rsp_error = r0_rsp.error;
    r0_rsp_data  = r0_rsp.data;
    r1_rsp_valid = r1_rsp.valid;
    r1_rsp_error = r1_rsp.error;
    r1_rsp_data  = r1_rsp.data;
  end

endmodule

// File: tb/tb_block_memory_arbiter.sv
// Directed bench for block_memory_arbiter with a byte-enabled 1-cycle RAM model.
// Each applyStimulus call advances one clock; responses appear in the next call.
module tb_block_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_ready, r0_rsp_valid, r0_rsp_error;
  logic [31:0] r0_address, r0_write_data, r0_rsp_data;
  logic [3:0]  r0_write_enable;
  logic        r1_valid, r1_ready, r1_rsp_valid, r1_rsp_error;
  logic [31:0] r1_address, r1_write_data, r1_rsp_data;
  logic [3:0]  r1_write_enable;
  logic [31:0] mem_address, mem_write_input, mem_read_output;
  logic [3:0]  mem_write_enable;

  logic [31:0] ram [0:8191];
  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  block_memory_arbiter #(.RAM_BLOCKS(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_address(r0_address),
    .r0_write_enable(r0_write_enable), .r0_write_data(r0_write_data),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_error(r0_rsp_error), .r0_rsp_data(r0_rsp_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_address(r1_address),
    .r1_write_enable(r1_write_enable), .r1_write_data(r1_write_data),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_error(r1_rsp_error), .r1_rsp_data(r1_rsp_data),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_write_input(mem_write_input), .mem_read_output(mem_read_output)
  );

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_write_enable[b]) ram[mem_address[12:0]][b*8 +: 8] <= mem_write_input[b*8 +: 8];
    mem_read_output <= ram[mem_address[12:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic [31:0] a0, input logic [3:0] we0, input logic [31:0] d0,
                               input logic v1, input logic [31:0] a1, input logic [3:0] we1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    reset = rst;
    r0_valid = v0; r0_address = a0; r0_write_enable = we0; r0_write_data = d0;
    r1_valid = v1; r1_address = a1; r1_write_enable = we1; r1_write_data = d1;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0, 32'd0, 4'h0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
    ram[0]    = 32'h12345678;
    ram[5]    = 32'hDEADBEEF;
    ram[2049] = 32'h11223344;
    ram[8191] = 32'hCAFEF00D;
    reset = 1'b1;
    r0_valid = 0; r0_address = 0; r0_write_enable = 0; r0_write_data = 0;
    r1_valid = 0; r1_address = 0; r1_write_enable = 0; r1_write_data = 0;

    // Requests during reset must not be granted nor write the RAM.
    applyStimulus(1'b1, 1'b1, 32'd5, 4'hF, 32'h55555555, 1'b1, 32'd6, 4'hF, 32'h66666666);
    applyStimulus(1'b1, 1'b1, 32'd5, 4'hF, 32'h55555555, 1'b1, 32'd6, 4'hF, 32'h66666666);
    checkOutput("reset_r0_ready", 32'(r0_ready), 32'd0);
    checkOutput("reset_r1_ready", 32'(r1_ready), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_write_enable), 32'd0);
    idleCycle();
    checkOutput("post_reset_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
    checkOutput("post_reset_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    checkOutput("post_reset_starve", 32'(dut.starve_count_q), 32'd0);
    checkOutput("reset_ram5_untouched", ram[5], 32'hDEADBEEF);

    // Single read by r0.
    applyStimulus(1'b0, 1'b1, 32'd5, 4'h0, 32'd0, 1'b0, 32'd0, 4'h0, 32'd0);
    checkOutput("rd_r0_ready", 32'(r0_ready), 32'd1);
    checkOutput("rd_mem_address", mem_address, 32'd5);
    checkOutput("rd_mem_we", 32'(mem_write_enable), 32'd0);
    idleCycle();
    checkOutput("rd_r0_rsp_valid", 32'(r0_rsp_valid), 32'd1);
    checkOutput("rd_r0_rsp_error", 32'(r0_rsp_error), 32'd0);
    checkOutput("rd_r0_rsp_data", r0_rsp_data, 32'hDEADBEEF);
    checkOutput("rd_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    idleCycle();
    checkOutput("rd_r0_rsp_one_cycle", 32'(r0_rsp_valid), 32'd0);

    // Byte write by r1, then readback.
    applyStimulus(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, 32'd2049, 4'b0010, 32'hAABBCCDD);
    checkOutput("bw_r1_ready", 32'(r1_ready), 32'd1);
    checkOutput("bw_mem_we", 32'(mem_write_enable), 32'h2);
    checkOutput("bw_mem_wdata", mem_write_input, 32'hAABBCCDD);
    applyStimulus(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, 32'd2049, 4'b0000, 32'd0);
    checkOutput("bw_wr_rsp_valid", 32'(r1_rsp_valid), 32'd1);
    checkOutput("bw_wr_rsp_data", r1_rsp_data, 32'h0);
    checkOutput("bw_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
    idleCycle();
    checkOutput("bw_rd_rsp_valid", 32'(r1_rsp_valid), 32'd1);
    checkOutput("bw_rd_rsp_data", r1_rsp_data, 32'h1122CC44);

    // Write by r0 then immediate read by r1 of the same word.
    applyStimulus(1'b0, 1'b1, 32'd7, 4'hF, 32'h01020304, 1'b0, 32'd0, 4'h0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 4'h0, 32'd0, 1'b1, 32'd7, 4'h0, 32'd0);
    checkOutput("raw_r0_wr_rsp", 32'(r0_rsp_valid), 32'd1);
    idleCycle();
    checkOutput("raw_r1_rd_data", r1_rsp_data, 32'h01020304);
    idleCycle();

    // Contention: r1 granted every 9th cycle.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, 1'b1, 32'd0, 4'h0, 32'd0, 1'b1, 32'd1, 4'h0, 32'd0);
      checkOutput($sformatf("cont_r1_ready_%0d", i), 32'(r1_ready), (i % 9 == 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("cont_r0_ready_%0d", i), 32'(r0_ready), (i % 9 == 8) ? 32'd0 : 32'd1);
    end
    idleCycle();
    idleCycle();
    checkOutput("cont_starve_cleared", 32'(dut.starve_count_q), 32'd0);

    // Out-of-range read and write, plus the last valid word.
    applyStimulus(1'b0, 1'b1, 32'h2000, 4'h0, 32'd0, 1'b0, 32'd0, 4'h0, 32'd0);
    checkOutput("oor_rd_ready", 32'(r0_ready), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h2000, 4'hF, 32'hFFFFFFFF, 1'b0, 32'd0, 4'h0, 32'd0);
    checkOutput("oor_wr_mem_we", 32'(mem_write_enable), 32'd0);
    checkOutput("oor_rd_rsp_valid", 32'(r0_rsp_valid), 32'd1);
    checkOutput("oor_rd_rsp_error", 32'(r0_rsp_error), 32'd1);
    checkOutput("oor_rd_rsp_data", r0_rsp_data, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1FFF, 4'h0, 32'd0, 1'b0, 32'd0, 4'h0, 32'd0);
    checkOutput("oor_wr_rsp_error", 32'(r0_rsp_error), 32'd1);
    idleCycle();
    checkOutput("edge_rd_rsp_error", 32'(r0_rsp_error), 32'd0);
    checkOutput("edge_rd_rsp_data", r0_rsp_data, 32'hCAFEF00D);
    checkOutput("oor_ram0_untouched", ram[0], 32'h12345678);

    // Reset asserted while a response is in flight.
    applyStimulus(1'b0, 1'b1, 32'd5, 4'h0, 32'd0, 1'b1, 32'd6, 4'h0, 32'd0);
    checkOutput("rst_mid_r0_ready", 32'(r0_ready), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'd5, 4'hF, 32'h0BADF00D, 1'b1, 32'd6, 4'hF, 32'h0BADF00D);
    checkOutput("rst_mid_rsp_dropped", 32'(r0_rsp_valid), 32'd0);
    checkOutput("rst_mid_r0_ready_low", 32'(r0_ready), 32'd0);
    checkOutput("rst_mid_r1_ready_low", 32'(r1_ready), 32'd0);
    checkOutput("rst_mid_mem_we", 32'(mem_write_enable), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 4'h0, 32'd0, 1'b0, 32'd0, 4'h0, 32'd0);
    checkOutput("rst_mid_starve", 32'(dut.starve_count_q), 32'd0);
    checkOutput("rst_mid_ram5", ram[5], 32'hDEADBEEF);

    // Idle for 10 cycles with stale write enables on the inputs.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, 32'd9, 4'hF, 32'h77777777, 1'b0, 32'd9, 4'hF, 32'h77777777);
    checkOutput("idle_mem_we", 32'(mem_write_enable), 32'd0);
    checkOutput("idle_r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
    checkOutput("idle_r1_rsp_valid", 32'(r1_rsp_valid), 32'd0);
    checkOutput("idle_starve", 32'(dut.starve_count_q), 32'd0);
    checkOutput("idle_ram9", ram[9], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
